// File: rtl/fragment_hazard_scheduler_pkg.sv
// Shared widths and defaults for the fragment hazard scheduler.
// Field widths and the hazard window default live here so every file agrees.
package fragment_hazard_scheduler_pkg;

  localparam int FHS_INDEX_WIDTH      = 14;
  localparam int FHS_SCREEN_POS_WIDTH = 16;
  localparam int FHS_SUB_PIXEL_WIDTH  = 8;
  localparam int FHS_DEPTH_WIDTH      = 32;
  localparam int FHS_HAZARD_WINDOW    = 6;
  localparam int FHS_INFLIGHT_WIDTH   = 4;
  localparam int FHS_STAT_WIDTH       = 32;

  function automatic logic [FHS_STAT_WIDTH-1:0] sat_inc(input logic [FHS_STAT_WIDTH-1:0] v);
    return (&v) ? v : v + FHS_STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/IndexScoreboard.sv
// Shift register of recently issued framebuffer indices with a parallel compare.
// Latency: hazard is combinational from probe_index_i; no backpressure of its own.
module IndexScoreboard
  import fragment_hazard_scheduler_pkg::*;
#(
  parameter int INDEX_WIDTH = FHS_INDEX_WIDTH,
  parameter int DEPTH       = FHS_HAZARD_WINDOW
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic [INDEX_WIDTH-1:0] push_index_i,
  input  logic [INDEX_WIDTH-1:0] probe_index_i,
  output logic                   hazard_o
);

  logic [DEPTH-1:0]       valid_q;
  logic [INDEX_WIDTH-1:0] index_q [DEPTH];

  // Entry i holds what was issued i+1 cycles ago; it ages out after DEPTH cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) index_q[i] <= '0;
    end else begin
      valid_q[0] <= push_i;
      index_q[0] <= push_index_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        index_q[i] <= index_q[i-1];
      end
    end
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (index_q[i] == probe_index_i)) hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/fragment_hazard_scheduler.sv
// Issues fragments one per cycle unless the same framebuffer index was issued recently.
// Latency 1 cycle s->m; s_ready drops only on an index hazard, the m side never stalls.
module fragment_hazard_scheduler
  import fragment_hazard_scheduler_pkg::*;
#(
  parameter int FRAMEBUFFER_INDEX_WIDTH = FHS_INDEX_WIDTH,
  parameter int SCREEN_POS_WIDTH        = FHS_SCREEN_POS_WIDTH,
  parameter int SUB_PIXEL_WIDTH         = FHS_SUB_PIXEL_WIDTH,
  parameter int HAZARD_WINDOW           = FHS_HAZARD_WINDOW
) (
  input  logic                               aclk,
  input  logic                               resetn,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [4*SUB_PIXEL_WIDTH-1:0]       s_fragmentColor,
  input  logic [FHS_DEPTH_WIDTH-1:0]         s_depth,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_index,
  input  logic [SCREEN_POS_WIDTH-1:0]        s_screenPosX,
  input  logic [SCREEN_POS_WIDTH-1:0]        s_screenPosY,
  output logic                               m_valid,
  output logic [4*SUB_PIXEL_WIDTH-1:0]       m_fragmentColor,
  output logic [FHS_DEPTH_WIDTH-1:0]         m_depth,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_index,
  output logic [SCREEN_POS_WIDTH-1:0]        m_screenPosX,
  output logic [SCREEN_POS_WIDTH-1:0]        m_screenPosY,
  input  logic                               fragmentProcessed,
  input  logic                               clearStats,
  output logic                               idle,
  output logic [FHS_STAT_WIDTH-1:0]          stallCycles
);

  localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;

  logic hazard;
  logic issue;
  logic retire;

  logic                               m_valid_q, m_valid_d;
  logic [PIXEL_WIDTH-1:0]             m_color_q, m_color_d;
  logic [FHS_DEPTH_WIDTH-1:0]         m_depth_q, m_depth_d;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_index_q, m_index_d;
  logic [SCREEN_POS_WIDTH-1:0]        m_pos_x_q, m_pos_x_d;
  logic [SCREEN_POS_WIDTH-1:0]        m_pos_y_q, m_pos_y_d;
  logic [FHS_INFLIGHT_WIDTH-1:0]      in_flight_q, in_flight_d;
  logic [FHS_STAT_WIDTH-1:0]          stall_cnt_q, stall_cnt_d;

  IndexScoreboard #(
    .INDEX_WIDTH (FRAMEBUFFER_INDEX_WIDTH),
    .DEPTH       (HAZARD_WINDOW)
  ) u_scoreboard (
    .clk_i         (aclk),
    .rst_n_i       (resetn),
    .push_i        (issue),
    .push_index_i  (s_index),
    .probe_index_i (s_index),
    .hazard_o      (hazard)
  );

  assign s_ready = ~hazard;
  assign issue   = s_valid & s_ready;
  // A retire with nothing in flight is a stray pulse and must not wrap the counter.
  assign retire  = fragmentProcessed & (in_flight_q != '0);

  always_comb begin
    m_valid_d   = issue;
    m_color_d   = m_color_q;
    m_depth_d   = m_depth_q;
    m_index_d   = m_index_q;
    m_pos_x_d   = m_pos_x_q;
    m_pos_y_d   = m_pos_y_q;
    in_flight_d = in_flight_q;
    stall_cnt_d = stall_cnt_q;

    if (issue) begin
      m_color_d = s_fragmentColor;
      m_depth_d = s_depth;
      m_index_d = s_index;
      m_pos_x_d = s_screenPosX;
      m_pos_y_d = s_screenPosY;
    end

    if (issue && !retire) begin
      in_flight_d = in_flight_q + FHS_INFLIGHT_WIDTH'(1);
    end else if (!issue && retire) begin
      in_flight_d = in_flight_q - FHS_INFLIGHT_WIDTH'(1);
    end

    if (clearStats) begin
      stall_cnt_d = '0;
    end else if (s_valid && !s_ready) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_valid_q   <= 1'b0;
      m_color_q   <= '0;
      m_depth_q   <= '0;
      m_index_q   <= '0;
      m_pos_x_q   <= '0;
      m_pos_y_q   <= '0;
      in_flight_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_color_q   <= m_color_d;
      m_depth_q   <= m_depth_d;
      m_index_q   <= m_index_d;
      m_pos_x_q   <= m_pos_x_d;
      m_pos_y_q   <= m_pos_y_d;
      in_flight_q <= in_flight_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign m_valid         = m_valid_q;
  assign m_fragmentColor = m_color_q;
  assign m_depth         = m_depth_q;
  assign m_index         = m_index_q;
  assign m_screenPosX    = m_pos_x_q;
  assign m_screenPosY    = m_pos_y_q;
  assign idle            = (in_flight_q == '0) & ~s_valid;
  assign stallCycles     = stall_cnt_q;

endmodule

// File: tb/tb_fragment_hazard_scheduler.sv
// Scoreboard bench: driver predicts each issue from a last-issue-time model, monitor checks m side.
module tb_fragment_hazard_scheduler;

  localparam int IW = 14;
  localparam int PW = 16;
  localparam int HW = 6;

  typedef struct packed {
    logic [31:0]   color;
    logic [31:0]   depth;
    logic [IW-1:0] idx;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
  } frag_t;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_fragmentColor = '0;
  logic [31:0]   s_depth = '0;
  logic [IW-1:0] s_index = '0;
  logic [PW-1:0] s_screenPosX = '0;
  logic [PW-1:0] s_screenPosY = '0;
  logic          m_valid;
  logic [31:0]   m_fragmentColor;
  logic [31:0]   m_depth;
  logic [IW-1:0] m_index;
  logic [PW-1:0] m_screenPosX;
  logic [PW-1:0] m_screenPosY;
  logic          fragmentProcessed = 1'b0;
  logic          clearStats = 1'b0;
  logic          idle;
  logic [31:0]   stallCycles;

  fragment_hazard_scheduler dut (
    .aclk              (aclk),
    .resetn            (resetn),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_fragmentColor   (s_fragmentColor),
    .s_depth           (s_depth),
    .s_index           (s_index),
    .s_screenPosX      (s_screenPosX),
    .s_screenPosY      (s_screenPosY),
    .m_valid           (m_valid),
    .m_fragmentColor   (m_fragmentColor),
    .m_depth           (m_depth),
    .m_index           (m_index),
    .m_screenPosX      (m_screenPosX),
    .m_screenPosY      (m_screenPosY),
    .fragmentProcessed (fragmentProcessed),
    .clearStats        (clearStats),
    .idle              (idle),
    .stallCycles       (stallCycles)
  );

  always #5 aclk = ~aclk;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_issue [int];
  int    mdl_inflight = 0;
  logic [31:0] mdl_stall = '0;
  frag_t exp_q [$];
  int    mv_count = 0;
  logic  dut_rdy_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // An index may issue only if its last issue is more than HW cycles in the past.
  function automatic bit model_ready(input int idx);
    if (!last_issue.exists(idx)) return 1'b1;
    return (cyc - last_issue[idx]) > HW;
  endfunction

  function automatic void model_reset();
    last_issue.delete();
    mdl_inflight = 0;
    mdl_stall = '0;
    exp_q.delete();
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit v, input int idx, input bit proc, input bit clr, output bit acc);
    frag_t f;
    bit    rdy;
    f.color = $urandom;
    f.depth = $urandom;
    f.idx   = idx[IW-1:0];
    f.x     = PW'($urandom);
    f.y     = PW'($urandom);
    s_valid = v;
    s_index = f.idx;
    s_fragmentColor = f.color;
    s_depth = f.depth;
    s_screenPosX = f.x;
    s_screenPosY = f.y;
    fragmentProcessed = proc;
    clearStats = clr;
    #1;
    rdy = model_ready(idx);
    dut_rdy_seen = s_ready;
    check("s_ready", 128'(s_ready), 128'(rdy));
    check("idle", 128'(idle), 128'((mdl_inflight == 0) && !v));
    check("stallCycles", 128'(stallCycles), 128'(mdl_stall));
    acc = v && rdy;
    if (acc) begin
      exp_q.push_back(f);
      last_issue[idx] = cyc;
    end
    if (acc && !(proc && mdl_inflight > 0)) mdl_inflight++;
    else if (!acc && proc && mdl_inflight > 0) mdl_inflight--;
    if (clr) mdl_stall = '0;
    else if (v && !rdy && mdl_stall != 32'hFFFF_FFFF) mdl_stall++;
    @(negedge aclk);
    cyc++;
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 20 && mdl_inflight > 0; k++) drive(0, 0, 1, 0, a);
  endtask

  // Re-presents idx until the model accepts it; returns how often the DUT said not-ready.
  task automatic hold_until_accept(input int idx, output int lows);
    bit a;
    lows = 0;
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) begin
      drive(1, idx, 0, 0, a);
      if (!dut_rdy_seen) lows++;
    end
    check("accepted_within_bound", 128'(a), 128'(1));
  endtask

  always @(posedge aclk) begin
    #1;
    if (resetn && m_valid) begin
      frag_t e;
      mv_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: m_index %0h with nothing expected", m_index);
      end else begin
        e = exp_q.pop_front();
        check("m_index", 128'(m_index), 128'(e.idx));
        check("m_fragmentColor", 128'(m_fragmentColor), 128'(e.color));
        check("m_depth", 128'(m_depth), 128'(e.depth));
        check("m_screenPosX", 128'(m_screenPosX), 128'(e.x));
        check("m_screenPosY", 128'(m_screenPosY), 128'(e.y));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit acc;
    int cnt;
    int lows;
    logic [31:0] st0;

    repeat (2) @(negedge aclk);
    #1;
    check("reset_m_valid", 128'(m_valid), 128'(0));
    check("reset_m_index", 128'(m_index), 128'(0));
    check("reset_m_color", 128'(m_fragmentColor), 128'(0));
    check("reset_stall", 128'(stallCycles), 128'(0));
    check("reset_idle", 128'(idle), 128'(1));
    check("reset_s_ready", 128'(s_ready), 128'(1));
    @(negedge aclk);
    resetn = 1'b1;

    // Streaming distinct indices
    cnt = mv_count;
    st0 = stallCycles;
    for (int i = 0; i < 8; i++) drive(1, i, 0, 0, acc);
    check("stream_pulses", 128'(mv_count - cnt), 128'(8));
    check("stream_stall", 128'(stallCycles - st0), 128'(0));
    drain();

    // Same index back to back
    drive(1, 'h100, 0, 0, acc);
    st0 = stallCycles;
    hold_until_accept('h100, lows);
    check("hazard_ready_lows", 128'(lows), 128'(6));
    check("hazard_stall_delta", 128'(stallCycles - st0), 128'(6));
    drain();

    // Mixed stream 0x10, 0x20, 0x10
    drive(1, 'h10, 0, 0, acc);
    drive(1, 'h20, 0, 0, acc);
    st0 = stallCycles;
    hold_until_accept('h10, lows);
    check("mixed_ready_lows", 128'(lows), 128'(5));
    check("mixed_stall_delta", 128'(stallCycles - st0), 128'(5));

    // Asynchronous reset mid-stream
    drive(1, 'h30, 0, 0, acc);
    drive(1, 'h30, 0, 0, acc);
    drive(1, 'h31, 0, 0, acc);
    check("pre_reset_m_valid", 128'(m_valid), 128'(1));
    s_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("async_reset_m_valid", 128'(m_valid), 128'(0));
    check("async_reset_stall", 128'(stallCycles), 128'(0));
    check("async_reset_idle", 128'(idle), 128'(1));
    model_reset();
    @(negedge aclk);
    resetn = 1'b1;
    drive(1, 'h30, 0, 0, acc);
    check("post_reset_ready", 128'(dut_rdy_seen), 128'(1));
    drain();

    // In-flight counter and idle
    drive(1, 'h40, 0, 0, acc);
    drive(1, 'h41, 0, 0, acc);
    drive(1, 'h42, 0, 0, acc);
    drive(0, 0, 1, 0, acc);
    drive(1, 'h43, 1, 0, acc);
    drive(0, 0, 1, 0, acc);
    drive(0, 0, 0, 0, acc);
    drive(0, 0, 1, 0, acc);
    drive(0, 0, 0, 0, acc);
    check("idle_after_retire", 128'(idle), 128'(1));
    drive(0, 0, 1, 0, acc);
    drive(1, 'h44, 0, 0, acc);
    drive(0, 0, 0, 0, acc);
    drain();

    // Saturation and clear during a stall
    drive(1, 'h50, 0, 0, acc);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    release dut.stall_cnt_q;
    mdl_stall = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) drive(1, 'h50, 0, 0, acc);
    check("stall_saturated", 128'(stallCycles), 128'(32'hFFFF_FFFF));
    drive(1, 'h50, 0, 1, acc);
    check("stall_cleared", 128'(stallCycles), 128'(0));
    drive(1, 'h50, 0, 0, acc);
    drain();

    // Randomized traffic over a small index set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      int  idx;
      bit  v;
      bit  p;
      bit  c;
      idx = int'($urandom_range(0, 11));
      if ($urandom_range(0, 9) == 0) idx = idx + int'($urandom_range(1, 3)) * 'h1000;
      v = ($urandom_range(0, 3) != 0);
      p = (mdl_inflight >= 12) || ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 49) == 0);
      drive(v, idx, p, c, acc);
    end
    drive(0, 0, 0, 0, acc);
    drain();
    drive(0, 0, 0, 0, acc);
    check("expected_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fragment_hazard_scheduler.md
FRAGMENT_HAZARD_SCHEDULER -- requirements
Module: fragment_hazard_scheduler

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- FRAMEBUFFER_INDEX_WIDTH, 14, framebuffer index width.
- SCREEN_POS_WIDTH, 16, screen position width.
- SUB_PIXEL_WIDTH, 8, colour channel width; PIXEL_WIDTH = 4*SUB_PIXEL_WIDTH.
- HAZARD_WINDOW, 6, cycles an issued index blocks re-issue of the same index (legal 1..14).

REQ-002 SHALL have ports (name, direction, width, meaning):
- aclk, in, 1, single clock.
- resetn, in, 1, asynchronous active-low reset.
- s_valid, in, 1, incoming fragment valid.
- s_ready, out, 1, fragment accepted when s_valid & s_ready.
- s_fragmentColor, in, PIXEL_WIDTH, fragment colour.
- s_depth, in, 32, fragment depth.
- s_index, in, FRAMEBUFFER_INDEX_WIDTH, framebuffer index.
- s_screenPosX, in, SCREEN_POS_WIDTH, screen position X.
- s_screenPosY, in, SCREEN_POS_WIDTH, screen position Y.
- m_valid, out, 1, issue to per-fragment pipeline; no backpressure.
- m_fragmentColor, m_depth, m_index, m_screenPosX, m_screenPosY, out, same widths as the s_ inputs, registered issued fields.
- fragmentProcessed, in, 1, retire pulse from the pipeline.
- clearStats, in, 1, synchronous clear of stallCycles.
- idle, out, 1, nothing pending or in flight.
- stallCycles, out, 32, saturating hazard-stall counter.

Function
REQ-003 SHALL assert s_ready = ~hazard, combinational from s_index and the scoreboard; hazard = any valid scoreboard entry whose index equals s_index.
REQ-004 SHALL define issue = s_valid & s_ready; s_ready SHALL NOT depend on m-side signals.
REQ-005 SHALL register outputs, one cycle of latency:
- m_valid <= issue.
- m_* fields <= s_* fields when issue; otherwise held.
REQ-006 SHALL keep a HAZARD_WINDOW-entry scoreboard shift register {valid, index}, shifted every cycle:
- entry[0] <= {issue, s_index}.
- entry[i] <= entry[i-1].
REQ-007 SHALL enforce the blocking window: for an index issued at cycle t, the same index SHALL NOT be accepted at cycles t+1..t+HAZARD_WINDOW; it is accepted at t+HAZARD_WINDOW+1 at the earliest.
REQ-008 SHALL never block distinct indices; back-to-back issue of distinct indices SHALL sustain one fragment per cycle.
REQ-009 SHALL keep a 4-bit inFlight counter:
- +1 on issue.
- -1 on fragmentProcessed.
- Unchanged when both occur in the same cycle.
- fragmentProcessed at inFlight==0 SHALL be ignored (no underflow).
REQ-010 SHALL drive idle = (inFlight==0) & ~s_valid, combinational.
REQ-011 SHALL update stallCycles each cycle:
- +1 when s_valid & ~s_ready, saturating at 0xFFFFFFFF.
- clearStats sets it to 0 and has priority over increment.
REQ-012 SHALL leave s_* fields unsampled when s_valid=0, with no effect on state.

Reset
REQ-013 SHALL apply resetn asynchronously, deassertion synchronised to aclk by the system.
REQ-014 SHALL reset to:
- m_valid=0 and m_* data=0.
- All scoreboard valid bits=0.
- inFlight=0.
- stallCycles=0.
REQ-015 SHALL treat reset mid-operation as discarding all in-flight tracking; the first fragment after reset issues without hazard.

Structure
REQ-016 SHALL take HAZARD_WINDOW default and the fragment field widths from the shared register/descriptor defines include, not local literals.
REQ-017 SHALL implement the scoreboard (shift register plus parallel index compare, hazard output) as one sub-module named IndexScoreboard.

Verification
REQ-018 SHALL cover these directed scenarios:
- Reset: resetn=0 mid-stream -> m_valid=0, idle=1 (with s_valid=0), stallCycles=0 immediately, asynchronously.
- Streaming: indices 0,1,2,3,4,5,6,7 on consecutive cycles -> 8 consecutive m_valid pulses, s_ready never low, stallCycles=0.
- Same-index hazard: index 0x100 at t, and index 0x100 presented again from t+1 -> s_ready low at t+1..t+6, accepted at t+7, stallCycles=6.
- Mixed stream: 0x10, 0x20, 0x10 back-to-back -> 0x10 and 0x20 issue at t and t+1, second 0x10 issues at t+7, stallCycles=5.
- Counter and idle: 3 issues then 3 fragmentProcessed pulses, one coinciding with a 4th issue -> inFlight 3->...->1; idle=1 only after the final retire with s_valid=0.
- Stats: force 2^32 stall cycles -> stallCycles holds 0xFFFFFFFF; clearStats during a stall -> 0 next cycle.
